// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Holds the FSM state encoding, requester ids and the address-check helper.
package mem_arb_pkg;

  localparam int DEPTH_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // Misaligned byte address or word index beyond the memory is an error access.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth[31:0]);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way request arbiter (fetch vs data) with a last-grant pointer.
// DATA_PRIO=1 lets data win every tie; otherwise ties alternate.
module rr_arb2 #(
  parameter int DATA_PRIO = 0
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic en,
  input  logic ireq,
  input  logic dreq,
  output logic igrant,
  output logic dgrant
);

  logic last_d_r;
  logic pick_d_s;

  // Choose the winner; the pointer starts at "fetch" so the first tie goes to data.
  always_comb begin
    pick_d_s = 1'b0;
    if (dreq && ireq) begin
      pick_d_s = (DATA_PRIO != 0) ? 1'b1 : ~last_d_r;
    end else if (dreq) begin
      pick_d_s = 1'b1;
    end else begin
      pick_d_s = 1'b0;
    end
    dgrant = en & dreq & pick_d_s;
    igrant = en & ireq & ~pick_d_s;
  end

  // Remember which port was granted last.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      last_d_r <= 1'b0;
    end else if (dgrant) begin
      last_d_r <= 1'b1;
    end else if (igrant) begin
      last_d_r <= 1'b0;
    end else begin
      last_d_r <= last_d_r;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a data port.
// Each accepted request takes three cycles: grant, memory access, response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int DATA_PRIO = 0
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic        IGnt,
  output logic        IValid,
  output logic [31:0] IRdata,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  output logic        DGnt,
  output logic        DValid,
  output logic [31:0] DRdata,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWd,
  input  logic [31:0] MemRd,
  output logic        Err
);

  logic [1:0]  state_r;
  req_id_e     id_r;
  logic        wr_r;
  logic        err_r;
  logic        arb_en_s;
  logic        acc_s;
  logic [31:0] gaddr_s;
  logic        gerr_s;

  // Grants are only possible in IDLE and are suppressed while reset is held.
  always_comb begin
    arb_en_s = Rst_n && (state_r == IDLE);
    acc_s    = IGnt | DGnt;
    gaddr_s  = DGnt ? DAddr : IAddr;
    gerr_s   = addr_err(gaddr_s, DEPTH);
  end

  rr_arb2 #(
    .DATA_PRIO(DATA_PRIO)
  ) u_arb (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .en    (arb_en_s),
    .ireq  (IReq),
    .dreq  (DReq),
    .igrant(IGnt),
    .dgrant(DGnt)
  );

  // Transaction sequencer.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE:    state_r <= acc_s ? ACCESS : IDLE;
        ACCESS:  state_r <= RESP;
        RESP:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Memory-side outputs are loaded on acceptance, so they are live only during ACCESS.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      MemWe   <= 1'b0;
      MemAddr <= 32'd0;
      MemWd   <= 32'd0;
    end else if (acc_s) begin
      MemWe   <= DGnt & DWe & ~gerr_s;
      MemAddr <= {2'b00, gaddr_s[31:2]};
      MemWd   <= DGnt ? DWdata : 32'd0;
    end else begin
      MemWe   <= 1'b0;
      MemAddr <= 32'd0;
      MemWd   <= 32'd0;
    end
  end

  // Requester context for the response phase; fetches never count as stores.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      id_r  <= REQ_I;
      wr_r  <= 1'b0;
      err_r <= 1'b0;
      Err   <= 1'b0;
    end else if (acc_s) begin
      id_r  <= DGnt ? REQ_D : REQ_I;
      wr_r  <= DGnt & DWe;
      err_r <= gerr_s;
      Err   <= Err | gerr_s;
    end else begin
      id_r  <= id_r;
      wr_r  <= wr_r;
      err_r <= err_r;
      Err   <= Err;
    end
  end

  // Responses: capture read data at the end of ACCESS; stores keep the old DRdata.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      IValid <= 1'b0;
      DValid <= 1'b0;
      IRdata <= 32'd0;
      DRdata <= 32'd0;
    end else begin
      IValid <= (state_r == ACCESS) && (id_r == REQ_I);
      DValid <= (state_r == ACCESS) && (id_r == REQ_D);
      if ((state_r == ACCESS) && (id_r == REQ_I)) begin
        IRdata <= err_r ? 32'd0 : MemRd;
      end else begin
        IRdata <= IRdata;
      end
      if ((state_r == ACCESS) && (id_r == REQ_D) && (err_r || !wr_r)) begin
        DRdata <= err_r ? 32'd0 : MemRd;
      end else begin
        DRdata <= DRdata;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 64; number of 32-bit words in the shared instruction/data memory.
REQ-002 Parameter DATA_PRIO, default 0; 1 gives fixed priority to the data port, 0 gives round-robin.
REQ-003 Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Rst_n  input  1  asynchronous, active-low reset.
REQ-005 IReq  input  1  instruction-fetch request; held until IGnt.
REQ-006 IAddr  input  32  fetch byte address; held until IGnt.
REQ-007 IGnt  output  1  one-cycle pulse: fetch request accepted.
REQ-008 IValid  output  1  one-cycle pulse: fetch response on IRdata.
REQ-009 IRdata  output  32  fetched word.
REQ-010 DReq, DWe  input  1 each  data request and write-enable; held until DGnt.
REQ-011 DAddr, DWdata  input  32 each  data byte address and write data; held until DGnt.
REQ-012 DGnt  output  1  one-cycle pulse: data request accepted.
REQ-013 DValid  output  1  one-cycle pulse: data load result or store acknowledge.
REQ-014 DRdata  output  32  loaded word.
REQ-015 MemWe  output  1  memory write enable.
REQ-016 MemAddr  output  32  memory word index.
REQ-017 MemWd  output  32  memory write data.
REQ-018 MemRd  input  32  memory combinational read data.
REQ-019 Err  output  1  sticky access-error flag.

Function
REQ-020 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on acceptance, ACCESS->RESP always, RESP->IDLE always.
REQ-021 Acceptance occurs only in IDLE: Gnt is combinational from the requests in IDLE; at most one Gnt per cycle.
REQ-022 Request latency: accept in cycle N, memory access in N+1, Valid in N+2; next acceptance no earlier than N+3.
REQ-023 Arbitration, DATA_PRIO=0: if only one port requests, grant it; if both request, grant the port not granted last; the last-granted pointer resets to instruction, so the first tie goes to data.
REQ-024 Arbitration, DATA_PRIO=1: DReq always wins a tie.
REQ-025 On acceptance, latch requester id, word index = addr[31:2], we, and wdata.
REQ-026 In ACCESS: MemAddr = latched index, MemWd = latched wdata, and MemWe = latched we, for exactly one cycle.
REQ-027 In ACCESS: MemRd is registered into the response register at the end of the cycle.
REQ-028 Outside ACCESS: MemWe=0, MemAddr=0, MemWd=0.
REQ-029 In RESP: pulse IValid or DValid for the latched requester.
REQ-030 IRdata/DRdata update only on a read response and hold their value otherwise; a store response leaves DRdata unchanged.
REQ-031 Instruction requests are read-only; DWe is ignored when the fetch port is granted.
REQ-032 Error condition: addr[1:0]!=0 or word index >= DEPTH.
REQ-033 On an error access: MemWe is forced to 0, the response still pulses Valid with Rdata=0, and Err sets and stays set until reset.
REQ-034 A request deasserted before Gnt is dropped silently.
REQ-035 A new request arriving during ACCESS/RESP waits; no Gnt is issued until IDLE.

Reset
REQ-036 Rst_n low immediately forces IDLE and clears IGnt, DGnt, IValid, DValid, MemWe, MemAddr, MemWd, IRdata, DRdata, Err, and the RR pointer.
REQ-037 Reset in ACCESS/RESP aborts the transaction: no Valid is issued, and a write in flight is cut off by MemWe clearing asynchronously.
REQ-038 After release, the first acceptance is possible on the first rising Clk edge with Rst_n high.

Structure
REQ-039 Shared package mem_arb_pkg holds the state enum (IDLE/ACCESS/RESP), the requester-id enum (REQ_I/REQ_D), and the default DEPTH constant 64.
REQ-040 Sub-module rr_arb2: 2-way arbiter with last-grant pointer and DATA_PRIO mode; the FSM and datapath stay in mem_arbiter.
REQ-041 The block connects directly to the existing single-port memory: MemWe->We, MemAddr->Addr, MemWd->Wd, MemRd<-Rd.

Verification
REQ-042 Fetch: IReq=1, IAddr=0x08, memory word 2 = 0x2010_0005 -> IGnt at N, MemAddr=2 at N+1, IValid with IRdata=0x2010_0005 at N+2.
REQ-043 Store then load: DWe=1, DAddr=0x10, DWdata=0xDEAD_BEEF -> MemWe=1 with MemAddr=4 for exactly one cycle, DValid at N+2; then a load of 0x10 -> DRdata=0xDEAD_BEEF.
REQ-044 Tie round-robin (DATA_PRIO=0): IReq and DReq held high for 4 transactions -> grant order D,I,D,I with a Gnt every 3 cycles.
REQ-045 Tie priority (DATA_PRIO=1): same stimulus -> D granted every time while DReq is held; I granted once DReq drops.
REQ-046 Errors: DAddr=0x102 store and IAddr=0x100 fetch (DEPTH=64) -> MemWe stays 0, Valid pulses with Rdata=0, Err=1 held until Rst_n.
REQ-047 Reset during ACCESS of a store -> MemWe drops immediately, no DValid, all outputs 0; a fresh fetch after release completes normally.
